// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC register and IF/ID pipeline register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              BrTaken,
  input  logic [PC_W-1:0]   BrTarget,
  output logic [PC_W-1:0]   ImemAddr,
  input  logic [INS_W-1:0]  ImemData,
  output logic [PC_W-1:0]   IfId_PC,
  output logic [INS_W-1:0]  IfId_Instr,
  output logic              IfId_Valid,
  output logic [6:0]        Opcode,
  output logic [31:0]       FetchCount,
  output logic [31:0]       StallCount
);

  localparam logic [INS_W-1:0] NOP_INSTR  = INS_W'(32'h0000_0013);
  localparam logic [PC_W-1:0]  ALIGN_MASK = ~PC_W'(3);
  localparam logic [PC_W-1:0]  PC_STEP    = PC_W'(4);

  typedef enum logic [1:0] {
    UPD_REDIRECT,
    UPD_HOLD,
    UPD_ADVANCE
  } update_e;

  update_e          upd;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  ifIdPc_q, ifIdPc_d;
  logic [INS_W-1:0] ifIdInstr_q, ifIdInstr_d;
  logic             ifIdValid_q, ifIdValid_d;
  logic [PC_W-1:0]  brTargetAligned;

  // Masking (rather than slicing) keeps the low target bits formally consumed.
  assign brTargetAligned = BrTarget & ALIGN_MASK;

  always_comb begin
    upd = UPD_ADVANCE;
    if (BrTaken) begin
      upd = UPD_REDIRECT;
    end else if (Stall) begin
      upd = UPD_HOLD;
    end
  end

  always_comb begin
    pc_d        = pc_q;
    ifIdPc_d    = ifIdPc_q;
    ifIdInstr_d = ifIdInstr_q;
    ifIdValid_d = ifIdValid_q;
    unique case (upd)
      UPD_REDIRECT: begin
        pc_d        = brTargetAligned;
        ifIdPc_d    = '0;
        ifIdInstr_d = NOP_INSTR;
        ifIdValid_d = 1'b0;
      end
      UPD_HOLD: begin
      end
      UPD_ADVANCE: begin
        pc_d        = pc_q + PC_STEP;
        ifIdPc_d    = pc_q;
        ifIdInstr_d = ImemData;
        ifIdValid_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC & ALIGN_MASK;
      ifIdPc_q    <= '0;
      ifIdInstr_q <= NOP_INSTR;
      ifIdValid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ifIdPc_q    <= ifIdPc_d;
      ifIdInstr_q <= ifIdInstr_d;
      ifIdValid_q <= ifIdValid_d;
    end
  end

  assign ImemAddr   = pc_q;
  assign IfId_PC    = ifIdPc_q;
  assign IfId_Instr = ifIdInstr_q;
  assign IfId_Valid = ifIdValid_q;
  assign Opcode     = ifIdInstr_q[6:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCnt_q, stallCnt_q;

  // Counters follow the same update decision as the pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      if (upd == UPD_ADVANCE) begin
        fetchCnt_q <= fetchCnt_q + 32'd1;
      end
      if (upd == UPD_HOLD) begin
        stallCnt_q <= stallCnt_q + 32'd1;
      end
    end
  end

  assign FetchCount = fetchCnt_q;
  assign StallCount = stallCnt_q;
`else
  assign FetchCount = '0;
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences,
// and randomized traffic compared against a behavioural reference model.
module tb_fetch_stage;

  localparam int              PC_W     = 9;
  localparam int              INS_W    = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam int              PC_MOD   = 1 << PC_W;

  logic              clk;
  logic              reset;
  logic              Stall;
  logic              BrTaken;
  logic [PC_W-1:0]   BrTarget;
  logic [PC_W-1:0]   ImemAddr;
  logic [INS_W-1:0]  ImemData;
  logic [PC_W-1:0]  IfId_PC;
  logic [INS_W-1:0]  IfId_Instr;
  logic              IfId_Valid;
  logic [6:0]        Opcode;
  logic [31:0]       FetchCount;
  logic [31:0]       StallCount;

  fetch_stage #(
    .PC_W     (PC_W),
    .INS_W    (INS_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .BrTaken    (BrTaken),
    .BrTarget   (BrTarget),
    .ImemAddr   (ImemAddr),
    .ImemData   (ImemData),
    .IfId_PC    (IfId_PC),
    .IfId_Instr (IfId_Instr),
    .IfId_Valid (IfId_Valid),
    .Opcode     (Opcode),
    .FetchCount (FetchCount),
    .StallCount (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word i holds i + 0x100.
  function automatic logic [31:0] imemWord(input int addr);
    return 32'h100 + 32'(addr / 4);
  endfunction

  assign ImemData = imemWord(int'(ImemAddr));

  // Reference model state
  int          mPc;
  int          mIfPc;
  logic [31:0] mIfInstr;
  bit          mIfValid;
  logic [31:0] mFetch;
  logic [31:0] mStall;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit st, input bit br, input int tgt);
    reset    = rst;
    Stall    = st;
    BrTaken  = br;
    BrTarget = PC_W'(tgt);
    if (rst) begin
      mPc      = int'(RESET_PC);
      mIfPc    = 0;
      mIfInstr = 32'h13;
      mIfValid = 0;
      mFetch   = 0;
      mStall   = 0;
    end else if (br) begin
      mPc      = (tgt % PC_MOD) - ((tgt % PC_MOD) % 4);
      mIfPc    = 0;
      mIfInstr = 32'h13;
      mIfValid = 0;
    end else if (st) begin
      mStall = mStall + 1;
    end else begin
      mIfPc    = mPc;
      mIfInstr = imemWord(mPc);
      mIfValid = 1;
      mPc      = (mPc + 4) % PC_MOD;
      mFetch   = mFetch + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] expFetch;
    logic [31:0] expStall;
`ifdef FETCH_PERF_CNT_EN
    expFetch = mFetch;
    expStall = mStall;
`else
    expFetch = 32'd0;
    expStall = 32'd0;
`endif
    compare({tag, ".ImemAddr"},   32'(ImemAddr),   32'(mPc));
    compare({tag, ".IfId_PC"},    32'(IfId_PC),    32'(mIfPc));
    compare({tag, ".IfId_Instr"}, IfId_Instr,      mIfInstr);
    compare({tag, ".IfId_Valid"}, 32'(IfId_Valid), 32'(mIfValid));
    compare({tag, ".Opcode"},     32'(Opcode),     32'(mIfInstr[6:0]));
    compare({tag, ".FetchCount"}, FetchCount,      expFetch);
    compare({tag, ".StallCount"}, StallCount,      expStall);
  endtask

  typedef struct {
    bit rst;
    bit stall;
    bit br;
    int tgt;
    int expAddr;
    bit expValid;
    int expIfPc;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] expInstr;
    string       tag;

    reset    = 1'b1;
    Stall    = 1'b0;
    BrTaken  = 1'b0;
    BrTarget = '0;

    //            rst st br tgt    addr   v  ifpc
    vecs[0]  = '{1, 0, 0, 0,     'h000, 0, 'h000};
    vecs[1]  = '{0, 1, 0, 0,     'h000, 0, 'h000};
    vecs[2]  = '{0, 0, 0, 0,     'h004, 1, 'h000};
    vecs[3]  = '{0, 0, 0, 0,     'h008, 1, 'h004};
    vecs[4]  = '{0, 0, 0, 0,     'h00C, 1, 'h008};
    vecs[5]  = '{0, 1, 0, 0,     'h00C, 1, 'h008};
    vecs[6]  = '{0, 1, 0, 0,     'h00C, 1, 'h008};
    vecs[7]  = '{0, 1, 0, 0,     'h00C, 1, 'h008};
    vecs[8]  = '{0, 0, 0, 0,     'h010, 1, 'h00C};
    vecs[9]  = '{0, 1, 1, 'h043, 'h040, 0, 'h000};
    vecs[10] = '{0, 0, 0, 0,     'h044, 1, 'h040};
    vecs[11] = '{0, 0, 1, 'h1FC, 'h1FC, 0, 'h000};
    vecs[12] = '{0, 0, 0, 0,     'h000, 1, 'h1FC};
    vecs[13] = '{0, 0, 0, 0,     'h004, 1, 'h000};
    vecs[14] = '{1, 1, 1, 'h080, 'h000, 0, 'h000};
    vecs[15] = '{0, 0, 0, 0,     'h004, 1, 'h000};

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      tag = $sformatf("vec%0d", i);
      expInstr = vecs[i].expValid ? 32'h100 + 32'(vecs[i].expIfPc / 4) : 32'h13;
      compare({tag, ".addr"},   32'(ImemAddr),   32'(vecs[i].expAddr));
      compare({tag, ".valid"},  32'(IfId_Valid), 32'(vecs[i].expValid));
      compare({tag, ".ifpc"},   32'(IfId_PC),    32'(vecs[i].expIfPc));
      compare({tag, ".instr"},  IfId_Instr,      expInstr);
      compare({tag, ".opcode"}, 32'(Opcode),     32'(expInstr[6:0]));
      checkOutput({tag, ".model"});
    end

    // Ten edges with two redirects: eight real loads into IF/ID.
    $display("[TB] perf counter sequence");
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, (i == 3 || i == 6), 'h20 * i);
      checkOutput($sformatf("perf%0d", i));
    end
`ifdef FETCH_PERF_CNT_EN
    compare("perf.FetchCount8", FetchCount, 32'd8);
`else
    compare("perf.FetchCount0", FetchCount, 32'd0);
`endif

    // Three stalled edges straight after a fresh fetch run.
    $display("[TB] stall run sequence");
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
    compare("stall.addr", 32'(ImemAddr), 32'h00C);
    compare("stall.ifpc", 32'(IfId_PC),  32'h008);
`ifdef FETCH_PERF_CNT_EN
    compare("stall.StallCount3", StallCount, 32'd3);
`else
    compare("stall.StallCount0", StallCount, 32'd0);
`endif
    applyStimulus(0, 0, 0, 0);
    compare("stall.resume", 32'(IfId_PC), 32'h00C);

    $display("[TB] randomized traffic");
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 9) < 3,
                    $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, PC_MOD - 1)));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
